// File: rtl/fib_multi_pkg.sv
// Shared definitions for the multi-channel Fibonacci generator: register
// offsets, CTRL/STATUS bit positions and the per-channel address stride.
package fib_multi_pkg;

  // Register selector, taken from address bits [3:2] inside a channel slot
  typedef enum logic [1:0] {
    REG_CTRL   = 2'd0,
    REG_DIV    = 2'd1,
    REG_VALUE  = 2'd2,
    REG_STATUS = 2'd3
  } reg_e;

  // Byte offsets of the registers inside one channel slot
  localparam logic [3:0] OFF_CTRL   = 4'h0;
  localparam logic [3:0] OFF_DIV    = 4'h4;
  localparam logic [3:0] OFF_VALUE  = 4'h8;
  localparam logic [3:0] OFF_STATUS = 4'hC;

  // CTRL bit positions
  localparam int CTRL_RUN   = 0;
  localparam int CTRL_CLEAR = 1;
  localparam int CTRL_IEN   = 2;
  localparam int CTRL_HALT  = 3;

  // STATUS bit positions
  localparam int STAT_OVF     = 0;
  localparam int STAT_RUNNING = 1;

  // Channel slots are 16 bytes apart inside the 256-byte window
  localparam int CH_STRIDE = 16;
  localparam int CH_SHIFT  = $clog2(CH_STRIDE);
  localparam int CH_IDX_W  = 8 - CH_SHIFT;

endpackage

// File: rtl/fib_channel.sv
// One Fibonacci channel: prescaler, a/b sequence registers, overflow handling
// and its CTRL/DIV/STATUS registers. IEN exists only with FIB_MULTI_IRQ_EN.
module fib_channel
  import fib_multi_pkg::*;
#(
  parameter int WIDTH = 30,
  parameter int DIVW  = 24
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              ctrl_we,
  input  logic              div_we,
  input  logic              status_we,
  input  logic [31:0]       wdata,
  input  reg_e              reg_sel,
  output logic [WIDTH-1:0]  value,
  output logic              irq_req,
  output logic [31:0]       rd_data
);

  logic             run;
  logic             halt;
  logic             ien;
  logic             ovf;
  logic [DIVW-1:0]  div;
  logic [DIVW-1:0]  cnt;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;

  logic             tick;
  logic             clear;
  logic [WIDTH:0]   sum;

  assign tick  = run && (cnt == div);
  assign clear = ctrl_we && wdata[CTRL_CLEAR];
  assign sum   = {1'b0, a} + {1'b0, b};

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order in the block.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      run  <= 1'b0;
      halt <= 1'b0;
      ovf  <= 1'b0;
      div  <= '0;
      cnt  <= '0;
      a    <= '0;
      b    <= WIDTH'(1);
    end else begin
      if (ctrl_we) begin
        run  <= wdata[CTRL_RUN];
        halt <= wdata[CTRL_HALT];
      end
      if (div_we) begin
        div <= wdata[DIVW-1:0];
      end

      // Prescaler: a DIV write restarts the count from zero
      if (div_we || tick) begin
        cnt <= '0;
      end else if (run) begin
        cnt <= cnt + DIVW'(1);
      end

      // W1C first so an overflow on the same edge wins
      if (status_we && wdata[STAT_OVF]) begin
        ovf <= 1'b0;
      end

      if (clear) begin
        a <= '0;
        b <= WIDTH'(1);
      end else if (tick) begin
        if (sum[WIDTH]) begin
          ovf <= 1'b1;
          if (halt) begin
            run <= 1'b0;
          end else begin
            a <= '0;
            b <= WIDTH'(1);
          end
        end else begin
          a <= b;
          b <= sum[WIDTH-1:0];
        end
      end
    end
  end

`ifdef FIB_MULTI_IRQ_EN
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      ien <= 1'b0;
    end else if (ctrl_we) begin
      ien <= wdata[CTRL_IEN];
    end
  end
`else
  assign ien = 1'b0;
`endif

  assign value   = a;
  assign irq_req = ovf & ien;

  // NOTE: every output of a combinational block gets a default first, so no
  // path through the case leaves it unassigned and infers a latch.
  always_comb begin
    rd_data = '0;
    unique case (reg_sel)
      REG_CTRL: begin
        rd_data[CTRL_RUN]  = run;
        rd_data[CTRL_IEN]  = ien;
        rd_data[CTRL_HALT] = halt;
      end
      REG_DIV:    rd_data[DIVW-1:0]  = div;
      REG_VALUE:  rd_data[WIDTH-1:0] = a;
      REG_STATUS: begin
        rd_data[STAT_OVF]     = ovf;
        rd_data[STAT_RUNNING] = run;
      end
    endcase
  end

  // Upper data bits and, without interrupts, the IEN bit are don't-cares
  logic unused_wdata;
  assign unused_wdata = ^wdata;

endmodule

// File: rtl/fib_multi.sv
// NCH-channel Fibonacci generator on a Wishbone slave. Optional interrupt
// support is enabled by defining FIB_MULTI_IRQ_EN.
module fib_multi
  import fib_multi_pkg::*;
#(
  parameter int          NCH   = 4,
  parameter int          WIDTH = 30,
  parameter int          DIVW  = 24,
  parameter logic [31:0] BASE  = 32'h3000_0000
) (
  input  logic                 wb_clk_i,
  input  logic                 reset_n,
  input  logic                 wbs_stb_i,
  input  logic                 wbs_cyc_i,
  input  logic                 wbs_we_i,
  input  logic [3:0]           wbs_sel_i,
  input  logic [31:0]          wbs_adr_i,
  input  logic [31:0]          wbs_dat_i,
  output logic                 wbs_ack_o,
  output logic [31:0]          wbs_dat_o,
  output logic [NCH*WIDTH-1:0] value_o,
  output logic                 irq_o
);

  logic                in_window;
  logic                access;
  logic                wr_commit;
  logic [CH_IDX_W-1:0] ch_idx;
  reg_e                reg_sel;

  logic [NCH-1:0]      ctrl_we;
  logic [NCH-1:0]      div_we;
  logic [NCH-1:0]      status_we;
  logic [NCH-1:0]      ch_irq;
  logic [WIDTH-1:0]    ch_value [NCH];
  logic [31:0]         ch_rd    [NCH];
  logic [31:0]         rd_mux;

  assign in_window = (wbs_adr_i[31:8] == BASE[31:8]);
  assign ch_idx    = wbs_adr_i[7:CH_SHIFT];
  assign reg_sel   = reg_e'(wbs_adr_i[3:2]);

  // Masking with the current ack enforces an idle cycle between acks
  assign access    = wbs_stb_i && wbs_cyc_i && in_window && !wbs_ack_o;
  assign wr_commit = access && wbs_we_i && (wbs_sel_i == 4'hF);

  always_comb begin
    ctrl_we   = '0;
    div_we    = '0;
    status_we = '0;
    for (int c = 0; c < NCH; c++) begin
      if (wr_commit && (ch_idx == CH_IDX_W'(c))) begin
        ctrl_we[c]   = (reg_sel == REG_CTRL);
        div_we[c]    = (reg_sel == REG_DIV);
        status_we[c] = (reg_sel == REG_STATUS);
      end
    end
  end

  // Slots beyond NCH fall through to zero
  always_comb begin
    rd_mux = '0;
    for (int c = 0; c < NCH; c++) begin
      if (ch_idx == CH_IDX_W'(c)) begin
        rd_mux = ch_rd[c];
      end
    end
  end

  for (genvar c = 0; c < NCH; c++) begin : g_ch
    fib_channel #(
      .WIDTH (WIDTH),
      .DIVW  (DIVW)
    ) u_ch (
      .clk       (wb_clk_i),
      .rst_n     (reset_n),
      .ctrl_we   (ctrl_we[c]),
      .div_we    (div_we[c]),
      .status_we (status_we[c]),
      .wdata     (wbs_dat_i),
      .reg_sel   (reg_sel),
      .value     (ch_value[c]),
      .irq_req   (ch_irq[c]),
      .rd_data   (ch_rd[c])
    );

    assign value_o[c*WIDTH +: WIDTH] = ch_value[c];
  end

  always_ff @(posedge wb_clk_i) begin
    if (!reset_n) begin
      wbs_ack_o <= 1'b0;
      wbs_dat_o <= '0;
    end else begin
      wbs_ack_o <= access;
      wbs_dat_o <= (access && !wbs_we_i) ? rd_mux : '0;
    end
  end

`ifdef FIB_MULTI_IRQ_EN
  always_ff @(posedge wb_clk_i) begin
    if (!reset_n) begin
      irq_o <= 1'b0;
    end else begin
      irq_o <= |ch_irq;
    end
  end
`else
  assign irq_o = 1'b0;

  logic unused_irq;
  assign unused_irq = ^ch_irq;
`endif

  logic unused_adr;
  assign unused_adr = ^wbs_adr_i[1:0];

endmodule
